alu_result_packer: RTL and testbench

ALU_RESULT_PACKER -- requirements
Module: alu_result_packer

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_result_packer.sv | 93 +++++++++
 tb/tb_alu_result_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result packer: opcodes, packet length, FSM states.
package alu_pkg;

   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned RESULT_W = 32;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned LEN_W    = 16;

   localparam logic [BYTE_W-1:0] OP_ECHO = 8'hEC;
   localparam logic [BYTE_W-1:0] OP_ADD  = 8'hAD;
   localparam logic [BYTE_W-1:0] OP_MUL  = 8'hAC;
   localparam logic [BYTE_W-1:0] OP_DIV  = 8'hD1;

   localparam logic [LEN_W-1:0] PKT_LEN_DEFAULT = 16'd8;

   localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Byte at a given packet position; layout is independent of the opcode value.
   function automatic logic [BYTE_W-1:0] pkt_byte(
      input logic [IDX_W-1:0]    idx,
      input logic [BYTE_W-1:0]   opcode,
      input logic                overflow,
      input logic [RESULT_W-1:0] result,
      input logic [LEN_W-1:0]    pkt_len
   );
      logic [BYTE_W-1:0] b;
      case (idx)
         3'd0:    b = opcode;
         3'd1:    b = {7'b0, overflow};
         3'd2:    b = pkt_len[7:0];
         3'd3:    b = pkt_len[15:8];
         3'd4:    b = result[7:0];
         3'd5:    b = result[15:8];
         3'd6:    b = result[23:16];
         default: b = result[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/alu_result_packer.sv
// Packs one ALU result into an 8-byte response and streams it byte by byte
// over a valid/ready interface towards a UART transmitter.
module alu_result_packer
   import alu_pkg::*;
#(
   parameter logic [15:0] PKT_LEN = PKT_LEN_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [7:0]  opcode_i,
   input  logic [31:0] result_i,
   input  logic        overflow_i,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [7:0]  tx_data_o,
   output logic        busy_o
);

   state_e                state_q,    state_d;
   logic [IDX_W-1:0]      idx_q,      idx_d;
   logic [BYTE_W-1:0]     opcode_q,   opcode_d;
   logic [RESULT_W-1:0]   result_q,   result_d;
   logic                  overflow_q, overflow_d;
   logic [BYTE_W-1:0]     tx_data_q,  tx_data_d;

   // State, byte index, captured result and the currently offered byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         opcode_q   <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         opcode_q   <= opcode_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Next state: capture on acceptance, step through bytes on each handshake.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      opcode_d   = opcode_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      tx_data_d  = tx_data_q;

      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               state_d    = ST_SEND;
               idx_d      = '0;
               opcode_d   = opcode_i;
               result_d   = result_i;
               overflow_d = overflow_i;
               tx_data_d  = opcode_i;
            end
         end
         ST_SEND: begin
            if (tx_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d   = ST_IDLE;
                  idx_d     = '0;
                  tx_data_d = '0;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  tx_data_d = pkt_byte(idx_q + 3'd1, opcode_q, overflow_q,
                                       result_q, PKT_LEN);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Ready is forced low while reset is held so nothing is accepted during reset.
   assign ready_o    = (state_q == ST_IDLE) && !rst;
   assign tx_valid_o = (state_q == ST_SEND);
   assign busy_o     = (state_q != ST_IDLE);
   assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// Randomised self-checking bench for alu_result_packer against a byte-list model.
module tb_alu_result_packer;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  opcode_i;
   logic [31:0] result_i;
   logic        overflow_i;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [7:0]  tx_data_o;
   logic        busy_o;

   int n_cmp;
   int n_err;

   logic [7:0] got_q[$];
   int         stall_viol;
   int         idle_cyc;
   int         ready_in_send;
   int         cycles;
   bit         timeout;

   logic [7:0]  next_op;
   logic [31:0] next_res;
   logic        next_ovf;

   alu_result_packer dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .opcode_i   (opcode_i),
      .result_i   (result_i),
      .overflow_i (overflow_i),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .tx_data_o  (tx_data_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected byte k of a response packet, from the documented layout.
   function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [31:0] res,
                                           input logic ovf, input int k);
      int unsigned v;
      case (k)
         0:       v = int'(op);
         1:       v = ovf ? 1 : 0;
         2:       v = 8 % 256;
         3:       v = 8 / 256;
         default: v = (res / (32'd1 << (8 * (k - 4)))) % 256;
      endcase
      return 8'(v);
   endfunction

   // Drives tx_ready_i and records offered bytes until n handshakes or budget.
   // mode: 0 always ready, 1 ready every other cycle, 2 random.
   // inject: 0 none, 1 pulse a new D1 result mid-packet, 2 present next_* at start.
   task automatic collect(input int n, input int mode, input bit hold_valid, input int inject);
      logic [7:0] prev;
      bit         stalled;
      bit         r;
      got_q.delete();
      stall_viol    = 0;
      idle_cyc      = 0;
      ready_in_send = 0;
      cycles        = 0;
      timeout       = 1'b0;
      stalled       = 1'b0;
      prev          = 8'h00;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!hold_valid) valid_i = 1'b0;
         if (inject == 1 && cyc == 2) begin
            valid_i    = 1'b1;
            opcode_i   = 8'hD1;
            result_i   = 32'h5;
            overflow_i = 1'b1;
         end
         if (inject == 2 && cyc == 0) begin
            opcode_i   = next_op;
            result_i   = next_res;
            overflow_i = next_ovf;
         end
         cycles++;
         if (tx_valid_o) begin
            if (ready_o) ready_in_send++;
            if (stalled && tx_data_o !== prev) stall_viol++;
            case (mode)
               0:       r = 1'b1;
               1:       r = (cyc % 2 == 1);
               default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready_i = r;
            prev       = tx_data_o;
            stalled    = !r;
            if (r) got_q.push_back(tx_data_o);
         end else begin
            tx_ready_i = 1'b0;
            stalled    = 1'b0;
            idle_cyc++;
         end
         if (got_q.size() == n) break;
      end
      if (got_q.size() != n) timeout = 1'b1;
   endtask

   task automatic present(input logic [7:0] op, input logic [31:0] res, input logic ovf);
      @(negedge clk);
      tx_ready_i = 1'b0;
      valid_i    = 1'b1;
      opcode_i   = op;
      result_i   = res;
      overflow_i = ovf;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_i = 1'b0; tx_ready_i = 1'b0;
      opcode_i = 8'h00; result_i = 32'h0; overflow_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready_low got %b want 0", ready_o); end
      n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid_o); end
      n_cmp++; if (tx_data_o !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
      rst = 1'b0;
      #1;
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b want 1", ready_o); end
   endtask

   task automatic check_done(input string tag);
      @(negedge clk);
      tx_ready_i = 1'b0;
      n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL %s_done_tx_valid got %b want 0", tag, tx_valid_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL %s_done_ready got %b want 1", tag, ready_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL %s_done_busy got %b want 0", tag, busy_o); end
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] op, input logic [31:0] res,
                              input logic ovf);
      n_cmp++; if (timeout) begin n_err++; $display("FAIL %s_timeout got %0d bytes want 8", tag, got_q.size()); end
      for (int k = 0; k < 8 && k < got_q.size(); k++) begin
         n_cmp++;
         if (got_q[k] !== exp_byte(op, res, ovf, k)) begin
            n_err++;
            $display("FAIL %s_byte%0d got %h want %h", tag, k, got_q[k], exp_byte(op, res, ovf, k));
         end
      end
   endtask

   task automatic test_streaming();
      present(8'hAD, 32'h12345678, 1'b0);
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready got %b want 1", ready_o); end
      collect(8, 0, 1'b0, 0);
      check_bytes("stream", 8'hAD, 32'h12345678, 1'b0);
      n_cmp++; if (cycles !== 8 || idle_cyc !== 0) begin n_err++; $display("FAIL stream_cycles got %0d/%0d idle want 8/0", cycles, idle_cyc); end
      n_cmp++; if (ready_in_send !== 0) begin n_err++; $display("FAIL stream_ready_in_send got %0d want 0", ready_in_send); end
      check_done("stream");
   endtask

   task automatic test_stall();
      present(8'hAC, 32'hFFFFFFFF, 1'b1);
      collect(8, 1, 1'b0, 0);
      check_bytes("stall", 8'hAC, 32'hFFFFFFFF, 1'b1);
      n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
      n_cmp++; if (idle_cyc !== 0) begin n_err++; $display("FAIL stall_gap got %0d want 0", idle_cyc); end
      check_done("stall");
   endtask

   task automatic test_ignore_valid();
      present(8'hAD, 32'hCAFEF00D, 1'b0);
      collect(8, 0, 1'b0, 1);
      check_bytes("ignore", 8'hAD, 32'hCAFEF00D, 1'b0);
      n_cmp++; if (ready_in_send !== 0) begin n_err++; $display("FAIL ignore_ready_in_send got %0d want 0", ready_in_send); end
      check_done("ignore");
      repeat (2) begin
         @(negedge clk);
         n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL ignore_extra_packet got %b want 0", tx_valid_o); end
      end
   endtask

   task automatic test_abort();
      present(8'hAD, 32'h87654321, 1'b1);
      collect(4, 0, 1'b0, 0);
      check_bytes("abort_pre", 8'hAD, 32'h87654321, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      tx_ready_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_tx_valid got %b want 0", tx_valid_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy_o); end
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL abort_ready_in_rst got %b want 0", ready_o); end
      rst = 1'b0;
      tx_ready_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_residual got %b want 0", tx_valid_o); end
      end
      present(8'hEC, 32'hA5, 1'b0);
      collect(8, 2, 1'b0, 0);
      check_bytes("abort_post", 8'hEC, 32'hA5, 1'b0);
      check_done("abort_post");
   endtask

   task automatic test_back_to_back();
      logic [7:0]  op1;
      logic [31:0] res1;
      logic        ovf1;
      op1 = 8'(($urandom));
      res1 = $urandom;
      ovf1 = 1'($urandom_range(0, 1));
      next_op = 8'(($urandom));
      next_res = $urandom;
      next_ovf = 1'($urandom_range(0, 1));
      present(op1, res1, ovf1);
      collect(8, 2, 1'b1, 2);
      check_bytes("b2b_first", op1, res1, ovf1);
      @(negedge clk);
      tx_ready_i = 1'b0;
      n_cmp++; if (ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap got ready=%b tx_valid=%b want 1/0", ready_o, tx_valid_o); end
      collect(8, 0, 1'b0, 0);
      check_bytes("b2b_second", next_op, next_res, next_ovf);
      n_cmp++; if (idle_cyc !== 0) begin n_err++; $display("FAIL b2b_accept_delay got %0d idle want 0", idle_cyc); end
      check_done("b2b");
   endtask

   task automatic test_random();
      logic [7:0]  op;
      logic [31:0] res;
      logic        ovf;
      for (int p = 0; p < 6; p++) begin
         op  = 8'(($urandom));
         res = $urandom;
         ovf = 1'($urandom_range(0, 1));
         present(op, res, ovf);
         collect(8, 2, 1'b0, 0);
         check_bytes("rand", op, res, ovf);
         n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL rand_stable got %0d changes want 0", stall_viol); end
         check_done("rand");
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      next_op = 8'h00; next_res = 32'h0; next_ovf = 1'b0;
      test_reset();
      test_streaming();
      test_stall();
      test_ignore_valid();
      test_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
